// File: rtl/conv_pkg.sv
// Shared constants, enums and fan-out helpers for the convolution memory loader.
// Sizes cover a 5x5 filter over a 7x7 ifmap feeding five row-stationary PEs.
package conv_pkg;

  localparam int FILT_DIM   = 5;
  localparam int IFMAP_DIM  = 7;
  localparam int OUT_DIM    = 3;
  localparam int NUM_PE     = 5;
  localparam int TOTAL_PKTS = 130;

  typedef enum logic {
    PKT_FILT  = 1'b0,
    PKT_IFMAP = 1'b1
  } pkt_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } ld_state_t;

  // Filter row r lives in PE r; ifmap row r is consumed by PEs max(0,r-2)..min(4,r).
  function automatic logic [2:0] first_pe(pkt_type_t ph, logic [2:0] row);
    if (ph == PKT_FILT)                 return row;
    else if (row < 3'(OUT_DIM - 1))     return 3'd0;
    else                                return row - 3'(OUT_DIM - 1);
  endfunction

  function automatic logic [2:0] last_pe(pkt_type_t ph, logic [2:0] row);
    if (ph == PKT_FILT)                 return row;
    else if (row > 3'(NUM_PE - 1))      return 3'(NUM_PE - 1);
    else                                return row;
  endfunction

endpackage

// File: rtl/mem_read_hold.sv
// Issues one SRAM read and captures the returned word one cycle later.
// The captured value is held until the next read lands, so fan-out reuses it.
module mem_read_hold #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] hold_data
);

  logic pending;

  assign mem_rd_en = rd_req;
  assign mem_addr  = rd_req ? rd_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      hold_data <= '0;
    end else begin
      pending <= rd_req;
      if (pending) hold_data <= mem_rdata;
    end
  end

endmodule

// File: rtl/conv_mem_loader.sv
// Streams filter then ifmap words from SRAM to the five PEs as addressed packets,
// bracketed by a start handshake in and a done handshake out.
//
//   state   | meaning
//   IDLE    | waiting for start token, start_ready high
//   RD      | SRAM read strobe for current element, pick first consumer PE
//   WAIT    | SRAM data returns into hold register
//   SEND    | packet offered to PE network, one per consumer
//   DONE    | done token offered until accepted
module conv_mem_loader
  import conv_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 7,
  parameter int FILT_BASE  = 0,
  parameter int IFMAP_BASE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [2:0]        pkt_dest,
  output logic              pkt_type,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_last,
  output logic              busy
);

  ld_state_t         state, state_nxt;
  pkt_type_t         phase;
  logic [2:0]        row, col, dest, max_idx;
  logic [7:0]        pkt_cnt;
  logic              rd_req, accept, send_hs, more_dest, last_col, last_row;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] hold_data;

  assign max_idx   = (phase == PKT_FILT) ? 3'(FILT_DIM - 1) : 3'(IFMAP_DIM - 1);
  assign last_col  = (col == max_idx);
  assign last_row  = (row == max_idx);
  assign more_dest = (dest != last_pe(phase, row));
  assign accept    = (state == ST_IDLE) && start_valid;
  assign send_hs   = (state == ST_SEND) && pkt_ready;

  always_comb begin
    if (phase == PKT_FILT)
      rd_addr = ADDR_W'(FILT_BASE) + ADDR_W'(row) * ADDR_W'(FILT_DIM) + ADDR_W'(col);
    else
      rd_addr = ADDR_W'(IFMAP_BASE) + ADDR_W'(row) * ADDR_W'(IFMAP_DIM) + ADDR_W'(col);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    case (state)
      ST_IDLE: if (start_valid) state_nxt = ST_RD;
      ST_RD: begin
        rd_req    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: state_nxt = ST_SEND;
      ST_SEND: begin
        if (pkt_ready && !more_dest) begin
          if (phase == PKT_IFMAP && last_row && last_col) state_nxt = ST_DONE;
          else                                            state_nxt = ST_RD;
        end
      end
      ST_DONE: if (done_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= PKT_FILT;
      row     <= '0;
      col     <= '0;
      dest    <= '0;
      pkt_cnt <= '0;
    end else if (accept) begin
      phase   <= PKT_FILT;
      row     <= '0;
      col     <= '0;
      pkt_cnt <= '0;
    end else if (state == ST_RD) begin
      dest <= first_pe(phase, row);
    end else if (send_hs) begin
      pkt_cnt <= pkt_cnt + 8'd1;
      if (more_dest) begin
        dest <= dest + 3'd1;
      end else if (last_col) begin
        col <= '0;
        if (last_row) begin
          row <= '0;
          if (phase == PKT_FILT) phase <= PKT_IFMAP;
        end else begin
          row <= row + 3'd1;
        end
      end else begin
        col <= col + 3'd1;
      end
    end
  end

  mem_read_hold #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rd (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .hold_data(hold_data)
  );

  assign start_ready = (state == ST_IDLE);
  assign done_valid  = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);
  assign pkt_valid   = (state == ST_SEND);
  assign pkt_dest    = dest;
  assign pkt_type    = phase;
  assign pkt_data    = hold_data;
  assign pkt_last    = (state == ST_SEND) && (pkt_cnt == 8'(TOTAL_PKTS - 1));

endmodule

// File: tb/tb_conv_mem_loader.sv
// Scoreboard bench for conv_mem_loader: expected packets are queued at start,
// a monitor pops and compares on every accepted packet and checks stall stability.
module tb_conv_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid, start_ready, done_valid, done_ready;
  logic       mem_rd_en;
  logic [6:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       pkt_valid, pkt_ready, pkt_type, pkt_last, busy;
  logic [2:0] pkt_dest;
  logic [7:0] pkt_data;

  conv_mem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_dest   (pkt_dest),
    .pkt_type   (pkt_type),
    .pkt_data   (pkt_data),
    .pkt_last   (pkt_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic       ptype;
    logic [2:0] dest;
    logic [7:0] data;
  } pkt_t;

  pkt_t       exp_q[$];
  pkt_t       log_q[$];
  logic [7:0] mem[0:127];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         reads_53 = 0;
  logic       bp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      if (mem_addr == 7'd53) reads_53++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // monitor: scoreboard pop on handshake, stability while stalled, done counting
  logic stall_prev = 1'b0;
  pkt_t stall_pkt;
  always @(negedge clk) begin
    pkt_t act;
    act = '{pkt_last, pkt_type, pkt_dest, pkt_data};
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(pkt_valid), 32'd1);
        chk("stall_hold", 32'(act), 32'(stall_pkt));
      end
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pkt", 32'(act), 32'h1FFF);
        end else begin
          chk($sformatf("pkt%0d", log_q.size()), 32'(act), 32'(exp_q.pop_front()));
        end
        log_q.push_back(act);
      end
      stall_prev = pkt_valid && !pkt_ready;
      stall_pkt  = act;
      if (done_valid && done_ready) done_cnt++;
    end
  end

  initial begin
    pkt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pkt_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_load();
    pkt_t p;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        p = '{1'b0, 1'b0, 3'(r), mem[r * 5 + c]};
        exp_q.push_back(p);
      end
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        for (int pe = (r < 2 ? 0 : r - 2); pe <= (r > 4 ? 4 : r); pe++) begin
          p = '{(r == 6 && c == 6 && pe == 4), 1'b1, 3'(pe), mem[32 + r * 7 + c]};
          exp_q.push_back(p);
        end
  endtask

  task automatic do_start(output int t0);
    @(posedge clk);
    #1 start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic finish_done();
    @(posedge clk);
    #1 done_ready = 1'b1;
    @(posedge clk);
    #1 done_ready = 1'b0;
    chk("done_dropped", 32'(done_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_start_ready", 32'(start_ready), 32'd1);
  endtask

  task automatic wait_done();
    int seen;
    seen = 0;
    for (int i = 0; i < 4000 && seen == 0; i++) begin
      @(negedge clk);
      if (done_valid) seen = 1;
    end
    if (seen == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
    chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
    chk({tag, "_pkt_dest"}, 32'(pkt_dest), 32'd0);
    chk({tag, "_pkt_type"}, 32'(pkt_type), 32'd0);
    chk({tag, "_pkt_data"}, 32'(pkt_data), 32'd0);
    chk({tag, "_pkt_last"}, 32'(pkt_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t0, k, first_rd, first_pv, done_k, r53, dc, hit;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    start_valid = 1'b0;
    done_ready  = 1'b0;
    mem_rdata   = '0;

    // reset values
    repeat (3) @(posedge clk);
    #2 chk_reset_outs("rst");
    #1 rst_n = 1'b1;

    // full load, no backpressure, latency checks
    log_q.delete();
    push_load();
    do_start(t0);
    first_rd = -1; first_pv = -1; done_k = -1;
    for (int i = 0; i < 2000 && done_k < 0; i++) begin
      @(negedge clk);
      k = cyc - t0 + 1;
      if (mem_rd_en && first_rd < 0) first_rd = k;
      if (pkt_valid && first_pv < 0) first_pv = k;
      if (done_valid) done_k = k;
    end
    chk("first_rd_cycle", 32'(first_rd), 32'd1);
    chk("first_pkt_cycle", 32'(first_pv), 32'd3);
    chk("done_cycle", 32'(done_k), 32'd279);
    chk("done_busy", 32'(busy), 32'd1);
    finish_done();
    chk("t1_pkt_count", 32'(log_q.size()), 32'd130);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    if (log_q.size() == 130) begin
      chk("t1_pkt0", 32'(log_q[0]), {19'd0, 1'b0, 1'b0, 3'd0, 8'd0});
      chk("t1_pkt25", 32'(log_q[25]), {19'd0, 1'b0, 1'b1, 3'd0, 8'd32});
      chk("t1_pkt129", 32'(log_q[129]), {19'd0, 1'b1, 1'b1, 3'd4, 8'd80});
    end
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // backpressure, stray start pulses, held done
    mem[53] = 8'hA5;
    bp_en = 1'b1;
    log_q.delete();
    push_load();
    r53 = reads_53;
    do_start(t0);
    hit = 0;
    for (int i = 0; i < 4000 && hit == 0; i++) begin
      @(posedge clk);
      #1 start_valid = (i == 40 || i == 200);
      if (done_valid) hit = 1;
    end
    start_valid = 1'b0;
    if (hit == 0) chk("t2_done_timeout", 32'd0, 32'd1);
    bp_en = 1'b0;
    start_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 start_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_done_hold", 32'({done_valid, busy}), 32'b11);
    end
    finish_done();
    chk("t2_pkt_count", 32'(log_q.size()), 32'd130);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    if (log_q.size() == 130) begin
      chk("t2_pix30_a", 32'(log_q[67]), {19'd0, 1'b0, 1'b1, 3'd1, 8'hA5});
      chk("t2_pix30_b", 32'(log_q[68]), {19'd0, 1'b0, 1'b1, 3'd2, 8'hA5});
      chk("t2_pix30_c", 32'(log_q[69]), {19'd0, 1'b0, 1'b1, 3'd3, 8'hA5});
    end
    chk("t2_reads_53", 32'(reads_53 - r53), 32'd1);
    chk("t2_done_cnt", 32'(done_cnt), 32'd2);
    repeat (3) @(negedge clk);
    chk("t2_stays_idle", 32'({busy, mem_rd_en}), 32'd0);

    // reset mid-load, then replay from filter(0,0)
    log_q.delete();
    push_load();
    do_start(t0);
    hit = 0;
    for (int i = 0; i < 1000 && hit == 0; i++) begin
      @(posedge clk);
      #3;
      if (log_q.size() >= 60 && pkt_valid) hit = 1;
    end
    chk("t3_reached_60", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_outs("t3_rst");
    exp_q.delete();
    dc = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_no_resume", 32'({busy, pkt_valid}), 32'd0);
    chk("t3_no_done", 32'(done_cnt), 32'(dc));
    log_q.delete();
    push_load();
    do_start(t0);
    wait_done();
    finish_done();
    chk("t3_pkt_count", 32'(log_q.size()), 32'd130);
    if (log_q.size() > 0)
      chk("t3_replay_pkt0", 32'(log_q[0]), {19'd0, 1'b0, 1'b0, 3'd0, 8'd0});
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/conv_mem_loader.md
# conv_mem_loader

Clocked memory-streaming stage sitting directly downstream of the control center's memory start token. On a start handshake it reads the 5x5 filter and 7x7 input feature map from a synchronous SRAM and streams them as addressed packets to the five row-stationary PEs. It then returns a done handshake to the control center. Filter rows load first, then ifmap rows fanned out to every PE that consumes them.

## Interface
- DATA_W, 8, width of one filter weight / ifmap pixel
- ADDR_W, 7, SRAM address width
- FILT_BASE, 0, SRAM address of filter[0][0]; row-major, 25 words
- IFMAP_BASE, 32, SRAM address of ifmap[0][0]; row-major, 49 words
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_valid  in  1  start token from control center
- start_ready  out  1  loader can accept start (IDLE only)
- done_valid  out  1  load complete token to control center
- done_ready  in  1  control center accepts done
- mem_rd_en  out  1  SRAM read strobe
- mem_addr  out  ADDR_W  SRAM read address
- mem_rdata  in  DATA_W  SRAM data, valid the cycle after mem_rd_en
- pkt_valid  out  1  packet to PE network valid
- pkt_ready  in  1  network accepts packet
- pkt_dest  out  3  destination PE index 0..4
- pkt_type  out  1  0 = filter weight, 1 = ifmap pixel
- pkt_data  out  DATA_W  payload
- pkt_last  out  1  high on final packet of the load (packet 130)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, RD, WAIT, SEND, DONE. Phase bit FILT/IFMAP. Counters: row (0..6), col (0..6), dest (0..4).
- IDLE: start_ready=1. On start_valid&&start_ready: phase=FILT, row=col=0, go RD.
- RD: mem_rd_en=1, mem_addr = FILT_BASE+row*5+col (FILT) or IFMAP_BASE+row*7+col (IFMAP); dest = first consumer; go WAIT.
- WAIT: capture mem_rdata into hold register; go SEND.
- SEND: pkt_valid=1, pkt_data=hold register. Without pkt_ready, all pkt_* outputs hold stable. On pkt_ready:
  - another consumer remains: dest++, stay SEND.
  - otherwise: advance col, then row, then phase; go RD. After the last IFMAP element, go DONE.
- FILT phase: element (r,c) goes to PE r only; 25 packets.
- IFMAP phase: pixel (r,c) goes to PEs p = max(0,r-2) .. min(4,r), ascending. Fan-out per row is 1,2,3,3,3,2,1, giving 105 packets. The hold register is read once per pixel and reused.
- Order: FILT then IFMAP, row-major, col inner; 130 packets total.
- DONE: done_valid=1 until done_ready, then IDLE.
- start_valid outside IDLE is ignored (start_ready=0).
- Address arithmetic is unsigned, ADDR_W wide. Max address is 80 with defaults; the parameters must keep the max address below 2^ADDR_W.

## Timing
- Reset (async assert, sync-clean deassert): state=IDLE, counters=0, hold register=0. Outputs: start_ready=1, done_valid=0, mem_rd_en=0, mem_addr=0, pkt_valid=0, pkt_dest=0, pkt_type=0, pkt_data=0, pkt_last=0, busy=0.
- Reset mid-load aborts immediately; no done is sent. A partial stream is not resumed.
- Start accepted at edge T: mem_rd_en in cycle T+1, first pkt_valid in cycle T+3.
- With pkt_ready tied high:
  - each filter element takes 3 cycles.
  - each ifmap pixel takes 2 cycles plus one per consumer.
  - total 25*3 + 49*2 + 105 = 278 cycles from start accept to DONE entry. done_valid rises in cycle T+279.
- Handshakes complete on the edge where valid&&ready are both 1. valid never drops without ready.

## Structure
- Shared package conv_pkg: FILT_DIM=5, IFMAP_DIM=7, OUT_DIM=3, NUM_PE=5, TOTAL_PKTS=130, pkt_type_t enum {PKT_FILT, PKT_IFMAP}, loader state enum.
- One sub-module: mem_read_hold. It issues the read, captures mem_rdata one cycle later, and holds the value until released. The FSM, counters and fan-out range logic stay in conv_mem_loader.

## Test plan
- Reset then start, pkt_ready=1, SRAM filled with address value. Required response:
  - 130 packets in stated order; first packet dest0/type0/data0.
  - packet 26 is dest0/type1/data32; ifmap(6,6) goes to PE4 only, with pkt_last=1.
  - done_valid at T+279.
- Random pkt_ready backpressure (50%): same 130-packet sequence; pkt_* stable while stalled.
- start_valid pulsed during load and during DONE: ignored; exactly one done. done_ready held low 10 cycles: done_valid stays 1, busy=1.
- rst_n asserted at packet 60 with pkt_valid high: all outputs at reset values asynchronously. A new start replays from filter(0,0).
- Pixel row 3 col 0 (addr 53, data 0xA5): three consecutive packets to dest 1,2,3, all data 0xA5, with one SRAM read.
